// File: rtl/muldiv_pkg.sv
// Shared constants and types for the RV32M multiply/divide unit.
// MULDIV_EARLY_OUT_EN (see muldiv_unit.sv) selects early-terminating multiplies.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Decode used by the main controller to enter EX_M
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the main controller (master) and muldiv_unit (slave).
interface muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, a, b, input busy, done, result);
  modport slave  (input start, funct3, a, b, output busy, done, result);
endinterface

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negation of a W-bit value.
module muldiv_negate #(
  parameter int unsigned W = 32
) (
  input  logic         neg_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] val_o
);
  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine (radix-2 shift-add, restoring division).
// Define MULDIV_EARLY_OUT_EN to let multiplies finish once the multiplier is exhausted.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);
  localparam int unsigned     CntW   = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opa_q, opa_d, opb_q, opb_d, result_q, result_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;

  logic            is_div, sign_a, sign_b, neg_start;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    is_div = bus.funct3[2];
    if (is_div) begin
      sign_a = ~bus.funct3[0] & bus.a[XLEN-1];
      sign_b = ~bus.funct3[0] & bus.b[XLEN-1];
    end else begin
      sign_a = (bus.funct3 == F3_MULH || bus.funct3 == F3_MULHSU) & bus.a[XLEN-1];
      sign_b = (bus.funct3 == F3_MULH) & bus.b[XLEN-1];
    end
    // Remainder follows the dividend; everything else follows the sign product
    neg_start = (is_div && bus.funct3[1]) ? sign_a : (sign_a ^ sign_b);
  end

  muldiv_negate #(.W(XLEN)) u_neg_a (.neg_i(sign_a), .val_i(bus.a), .val_o(mag_a));
  muldiv_negate #(.W(XLEN)) u_neg_b (.neg_i(sign_b), .val_i(bus.b), .val_o(mag_b));

  logic            spec_hit;
  logic [XLEN-1:0] spec_val;

  always_comb begin
    spec_hit = 1'b0;
    spec_val = '0;
    if (is_div && bus.b == '0) begin
      spec_hit = 1'b1;
      spec_val = bus.funct3[1] ? bus.a : '1;
    end else if (is_div && !bus.funct3[0] && bus.a == MinVal && bus.b == '1) begin
      spec_hit = 1'b1;
      spec_val = bus.funct3[1] ? '0 : MinVal;
    end
`ifdef MULDIV_EARLY_OUT_EN
    else if (!is_div && (bus.a == '0 || bus.b == '0)) begin
      spec_hit = 1'b1;
      spec_val = '0;
    end
`endif
  end

  logic [XLEN:0]     mul_sum, div_trial;
  logic [XLEN-1:0]   div_rem, opa_next, res_final;
  logic [2*XLEN-1:0] mul_acc, div_acc, acc_next, final_acc, raw_res, fix_res;
  logic              last;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q & {XLEN{opa_q[0]}}};
    mul_acc   = {mul_sum, acc_q[XLEN-1:1]};
    div_trial = {acc_q[2*XLEN-1:XLEN], opa_q[XLEN-1]} - {1'b0, opb_q};
    div_rem   = div_trial[XLEN] ? {acc_q[2*XLEN-2:XLEN], opa_q[XLEN-1]} : div_trial[XLEN-1:0];
    div_acc   = {div_rem, acc_q[XLEN-2:0], ~div_trial[XLEN]};
    acc_next  = op_q[2] ? div_acc : mul_acc;
    opa_next  = op_q[2] ? (opa_q << 1) : (opa_q >> 1);
    last      = (cnt_q == '0);
    final_acc = acc_next;
`ifdef MULDIV_EARLY_OUT_EN
    // Partial product still sits cnt_q places high; shift it down to finish now
    if (!op_q[2]) begin
      last      = last | (opa_next == '0);
      final_acc = mul_acc >> cnt_q;
    end
`endif
    raw_res = op_q[2] ? {{XLEN{1'b0}}, op_q[1] ? final_acc[2*XLEN-1:XLEN] : final_acc[XLEN-1:0]}
                      : final_acc;
  end

  muldiv_negate #(.W(2*XLEN)) u_neg_res (.neg_i(neg_q), .val_i(raw_res), .val_o(fix_res));

  assign res_final = (op_q[2] || op_q == F3_MUL) ? fix_res[XLEN-1:0] : fix_res[2*XLEN-1:XLEN];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.start) begin
          op_d  = bus.funct3;
          neg_d = neg_start;
          if (spec_hit) begin
            state_d  = StDone;
            result_d = spec_val;
          end else begin
            state_d = StRun;
            cnt_d   = CntW'(XLEN - 1);
            acc_d   = '0;
            opa_d   = mag_a;
            opb_d   = mag_b;
          end
        end
      end
      StRun: begin
        acc_d = acc_next;
        opa_d = opa_next;
        cnt_d = cnt_q - CntW'(1);
        if (last) begin
          state_d  = StDone;
          result_d = res_final;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q == StRun);
  assign bus.done   = (state_q == StDone);
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, corner sequences, random vs. model.
// Multiply latency expectations relax when MULDIV_EARLY_OUT_EN is defined.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned XLEN = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int MulLat = -1;
`else
  localparam int MulLat = 33;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_if #(.XLEN(XLEN)) bus ();
  muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  // Reference: plain 64-bit arithmetic plus the RISC-V divide corner rules
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = 64'(a) * 64'(b);
    if (f3 == F3_MULH) p = 64'(sa * sb);
    if (f3 == F3_MULHSU) p = 64'(sa * longint'({32'b0, b}));
    if (!f3[2]) return (f3 == F3_MUL) ? p[31:0] : p[63:32];
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : 32'h8000_0000;
    if (!f3[0]) return f3[1] ? 32'(sa % sb) : 32'(sa / sb);
    return f3[1] ? (a % b) : (a / b);
  endfunction

  // Edges from the start edge to the first cycle with done high; -1 = variable (2..33)
  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (!f3[2] && (a == 32'd0 || b == 32'd0)) return 1;
`endif
    if (!f3[2]) return MulLat;
    return 33;
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_lat(input string name, input int act, input int exp);
    checks++;
    if ((exp < 0) ? (act < 2 || act > 33) : (act != exp)) begin
      failures++;
      $display("FAIL %s latency actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busy_cnt,
                        output logic busy_at_done);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.a      = a;
    bus.b      = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat       = 1;
    busy_cnt  = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    res          = bus.result;
    busy_at_done = bus.busy;
  endtask

  task automatic run_and_check(input string name, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    logic [31:0] res;
    int          lat, busy_cnt;
    logic        bad;
    run_op(f3, a, b, res, lat, busy_cnt, bad);
    check_val({name, "_result"}, res, exp_res);
    check_lat(name, lat, exp_lat);
    check_val({name, "_busy_cycles"}, 32'(busy_cnt), 32'(lat - 1));
    check_val({name, "_busy_at_done"}, 32'(bad), 32'd0);
  endtask

  initial begin
    logic [31:0] res, ra, rb;
    logic [2:0]  rf;
    int          lat;
    logic        seen;

    vecs.push_back('{F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MulLat});
    vecs.push_back('{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MulLat});
    vecs.push_back('{F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, MulLat});
    vecs.push_back('{F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MulLat});
    vecs.push_back('{F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33});
    vecs.push_back('{F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33});
    vecs.push_back('{F3_DIVU,   32'd100,        32'd7,         32'd14,        33});
    vecs.push_back('{F3_REMU,   32'd100,        32'd7,         32'd2,         33});
    vecs.push_back('{F3_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{F3_REM,    32'd5,          32'd0,         32'd5,         1});
    vecs.push_back('{F3_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{F3_REMU,   32'd5,          32'd0,         32'd5,         1});
    vecs.push_back('{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1});
    vecs.push_back('{F3_MUL,    32'd3,          32'd5,         32'd15,        MulLat});

    bus.start  = 1'b0;
    bus.funct3 = '0;
    bus.a      = '0;
    bus.b      = '0;
    rst        = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_val("reset_busy", 32'(bus.busy), 32'd0);
    check_val("reset_done", 32'(bus.done), 32'd0);
    check_val("reset_result", bus.result, 32'd0);

    foreach (vecs[i]) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].res,
                    vecs[i].lat);
    end

    // start during RUN is ignored and operands are latched
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = F3_DIVU;
    bus.a      = 32'd100;
    bus.b      = 32'd7;
    @(posedge clk);
    #1;
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      bus.start = (lat == 5);
      if (lat == 5) begin
        bus.funct3 = F3_MUL;
        bus.a      = 32'd3;
        bus.b      = 32'd5;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    check_val("ignore_start_result", bus.result, 32'd14);
    check_lat("ignore_start", lat, 33);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check_val("done_pulse_clears", 32'(bus.done), 32'd0);
    check_val("result_held", bus.result, 32'd14);

    // reset at cycle 10 of RUN aborts without a done pulse
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = F3_DIV;
    bus.a      = 32'hFFFF_FFF9;
    bus.b      = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check_val("busy_before_abort", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("abort_busy", 32'(bus.busy), 32'd0);
    check_val("abort_done", 32'(bus.done), 32'd0);
    check_val("abort_result", bus.result, 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) seen = 1'b1;
    end
    check_val("abort_no_done", 32'(seen), 32'd0);

    // rst wins over a simultaneous start
    @(negedge clk);
    rst        = 1'b1;
    bus.start  = 1'b1;
    bus.funct3 = F3_REMU;
    bus.a      = 32'd9;
    bus.b      = 32'd0;
    @(posedge clk);
    #1;
    check_val("rst_prio_done", 32'(bus.done), 32'd0);
    check_val("rst_prio_result", bus.result, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;

    for (int i = 0; i < 150; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin
          ra = 32'h8000_0000;
          rb = 32'hFFFF_FFFF;
        end
        2: ra = $urandom_range(0, 255);
        3: rb = $urandom_range(1, 15);
        default: ;
      endcase
      run_and_check($sformatf("rnd%0d_f%0d_%h_%h", i, rf, ra, rb), rf, ra, rb,
                    ref_result(rf, ra, rb), ref_lat(rf, ra, rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
